// File: rtl/toeplitz_pkg.sv
// toeplitz_pkg
// Shared definitions for the Toeplitz-hashing extractor.
//   DEF_BS / DEF_N / DEF_L : default chunk width, raw bits per block, and
//                            extracted bits per block
//   SEED_W / SEED          : width and value of the Toeplitz seed, which
//                            fixes the L x N hashing matrix
//   partial_product()      : contribution of one received BS-bit chunk to
//                            the L-bit hash
package toeplitz_pkg;

    localparam int DEF_BS = 64;
    localparam int DEF_N  = 256;
    localparam int DEF_L  = 128;
    localparam int SEED_W = DEF_N + DEF_L - 1;

    localparam logic [SEED_W-1:0] SEED = {
        63'h5a3c_96e1_0f7b_d248,
        64'hc3e1_7a9b_2d4f_8e06,
        64'h1b7d_e390_a5c2_4f68,
        64'h9e2f_61d4_b8a7_03c5,
        64'h47f0_dc19_6e8b_a253,
        64'hb1d6_0e7c_39a4_f582
    };

    // Chunk k holds raw bits x[N-BS-k*BS +: BS]; chunk[BS-1] arrived first.
    // Bit m of the chunk is x[j] with j = N-BS-k*BS+m, whose matrix column is
    // SEED[N-1-j +: L] = SEED[k*BS + BS-1-m +: L].
    function automatic logic [DEF_L-1:0] partial_product(
        input logic [SEED_W-1:0] seed,
        input int                k,
        input logic [DEF_BS-1:0] chunk
    );
        logic [DEF_L-1:0] pp;
        pp = '0;
        for (int m = 0; m < DEF_BS; m++) begin
            if (chunk[m]) begin
                pp = pp ^ seed[k*DEF_BS + DEF_BS-1-m +: DEF_L];
            end
        end
        return pp;
    endfunction

endpackage

// File: rtl/serializer.sv
// serializer
// Shifts each freshly strobed hash word out MSB first.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low
//   q       : word to serialize
//   qstrobe : load q; a load while shifting restarts the sequence
//   qbit    : serial bit, q[L-1] first
//   qbiten  : qbit valid, high for exactly L cycles per load
module serializer
    import toeplitz_pkg::*;
#(
    parameter int L = DEF_L
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [L-1:0] q,
    input  logic         qstrobe,
    output logic         qbit,
    output logic         qbiten
);

    localparam int RW = $clog2(L + 1);

    logic [L-1:0]  sh;
    logic [RW-1:0] rem;

    // The load edge already presents q[L-1]; rem counts the bits still left.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh     <= '0;
            rem    <= '0;
            qbit   <= 1'b0;
            qbiten <= 1'b0;
        end else if (qstrobe) begin
            qbit   <= q[L-1];
            sh     <= q << 1;
            rem    <= RW'(L - 1);
            qbiten <= 1'b1;
        end else if (rem != '0) begin
            qbit   <= sh[L-1];
            sh     <= sh << 1;
            rem    <= rem - 1'b1;
            qbiten <= 1'b1;
        end else begin
            qbit   <= 1'b0;
            qbiten <= 1'b0;
        end
    end

endmodule

// File: rtl/toeplitz.sv
// toeplitz
// Hashing core: consumes one raw bit per clock and emits the L-bit Toeplitz
// hash of each N-bit block.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low
//   data    : raw bit, one per clock, first bit of a block is x[N-1]
//   q       : hash of the most recently completed block
//   qstrobe : one-cycle pulse, q has just been updated
module toeplitz
    import toeplitz_pkg::*;
#(
    parameter int BS = DEF_BS,
    parameter int N  = DEF_N,
    parameter int L  = DEF_L,
    parameter logic [N+L-2:0] SEED = toeplitz_pkg::SEED
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         data,
    output logic [L-1:0] q,
    output logic         qstrobe
);

    if (N % BS != 0) begin : g_bad_n
        $error("toeplitz: N must be a multiple of BS");
    end
    if (L % BS != 0) begin : g_bad_l
        $error("toeplitz: L must be a multiple of BS");
    end
    if (L > N) begin : g_bad_ln
        $error("toeplitz: L must not exceed N");
    end
    // The shared partial-product function is sized by the package defaults.
    if (BS != DEF_BS || N != DEF_N || L != DEF_L) begin : g_bad_pkg
        $error("toeplitz: BS/N/L must match toeplitz_pkg defaults");
    end

    localparam int CW = $clog2(N);

    logic [CW-1:0] cnt;
    logic [BS-1:0] chunk;
    logic [L-1:0]  acc;

    logic [BS-1:0] chunk_nxt;
    logic          chunk_done;
    logic          block_done;
    logic [L-1:0]  pp;

    // The chunk as it will look after this edge's bit is shifted in; its
    // product is folded in on the same edge that completes it.
    always_comb begin
        chunk_nxt  = {chunk[BS-2:0], data};
        chunk_done = (int'(cnt) % BS) == BS - 1;
        block_done = int'(cnt) == N - 1;
        pp         = partial_product(SEED, int'(cnt) / BS, chunk_nxt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            chunk   <= '0;
            acc     <= '0;
            q       <= '0;
            qstrobe <= 1'b0;
        end else begin
            chunk   <= chunk_nxt;
            qstrobe <= 1'b0;
            cnt     <= block_done ? '0 : cnt + 1'b1;
            if (chunk_done) begin
                if (block_done) begin
                    q       <= acc ^ pp;
                    acc     <= '0;
                    qstrobe <= 1'b1;
                end else begin
                    acc <= acc ^ pp;
                end
            end
        end
    end

endmodule

// File: rtl/toeplitz_extractor.sv
// toeplitz_extractor
// Streaming Toeplitz-hashing randomness extractor: N raw bits in, L hashed
// bits out per block, as a parallel word and as a serial stream.
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low
//   data    : raw bit, one per clock, no gaps
//   q       : hash of the most recent completed block
//   qstrobe : one-cycle pulse, q has just been updated
//   qbit    : serialized hash bit, MSB first
//   qbiten  : qbit valid
module toeplitz_extractor
    import toeplitz_pkg::*;
#(
    parameter int BS = DEF_BS,
    parameter int N  = DEF_N,
    parameter int L  = DEF_L,
    parameter logic [N+L-2:0] SEED = toeplitz_pkg::SEED
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         data,
    output logic [L-1:0] q,
    output logic         qstrobe,
    output logic         qbit,
    output logic         qbiten
);

    toeplitz #(
        .BS   (BS),
        .N    (N),
        .L    (L),
        .SEED (SEED)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .q       (q),
        .qstrobe (qstrobe)
    );

    serializer #(
        .L (L)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .q       (q),
        .qstrobe (qstrobe),
        .qbit    (qbit),
        .qbiten  (qbiten)
    );

endmodule

// File: tb/tb_toeplitz_extractor.sv
module tb_toeplitz_extractor;
    import toeplitz_pkg::*;

    localparam int N = DEF_N;
    localparam int L = DEF_L;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         data  = 1'b0;
    logic [L-1:0] q;
    logic         qstrobe;
    logic         qbit;
    logic         qbiten;

    // standalone serializer for directed word patterns
    logic [L-1:0] s_q   = '0;
    logic         s_stb = 1'b0;
    logic         s_bit;
    logic         s_en;

    toeplitz_extractor dut (
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .q       (q),
        .qstrobe (qstrobe),
        .qbit    (qbit),
        .qbiten  (qbiten)
    );

    serializer #(.L(L)) ser (
        .clk     (clk),
        .reset   (reset),
        .q       (s_q),
        .qstrobe (s_stb),
        .qbit    (s_bit),
        .qbiten  (s_en)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rel         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // observation record, sampled on the falling edge
    logic [L-1:0] mq[$];
    int           mt[$];
    logic         mb[$];
    int           rs[$];
    int           rl[$];
    int           cur_len   = 0;
    logic         prev_en   = 1'b0;
    int           hold_viol = 0;
    logic [L-1:0] prev_q    = '0;
    logic         prev_rst  = 1'b0;

    always @(negedge clk) begin
        if (qstrobe) begin
            mq.push_back(q);
            mt.push_back(cyc);
        end
        if (qbiten) begin
            mb.push_back(qbit);
            if (!prev_en) rs.push_back(cyc);
            cur_len = cur_len + 1;
        end else if (prev_en) begin
            rl.push_back(cur_len);
            cur_len = 0;
        end
        prev_en = qbiten;
        if (prev_rst && reset && !qstrobe && q !== prev_q) hold_viol = hold_viol + 1;
        prev_q   = q;
        prev_rst = reset;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Matrix definition: q[i] = XOR_j SEED[i-j+N-1] & x[j]
    function automatic logic [L-1:0] ref_hash(input logic [N-1:0] x);
        logic [L-1:0]     r;
        logic [N+L-2:0]   s;
        r = '0;
        s = SEED;
        for (int i = 0; i < L; i++)
            for (int j = 0; j < N; j++)
                if (x[j] & s[i-j+N-1]) r[i] = ~r[i];
        return r;
    endfunction

    function automatic logic [N-1:0] rand_block();
        logic [N-1:0] x;
        for (int w = 0; w < N/32; w++) x[w*32 +: 32] = $urandom;
        return x;
    endfunction

    task automatic clear_mon();
        mq.delete(); mt.delete(); mb.delete(); rs.delete(); rl.delete();
        cur_len   = 0;
        prev_en   = 1'b0;
        hold_viol = 0;
    endtask

    task automatic send_block(input logic [N-1:0] x);
        for (int i = N-1; i >= 0; i--) begin
            data = x[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        data = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        data  = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        clear_mon();
        rel = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        vectors++; if (q !== '0) begin miscompares++; $display("FAIL reset_q: got %h want 0", q); end
        vectors++; if (qstrobe !== 1'b0) begin miscompares++; $display("FAIL reset_qstrobe: got %b want 0", qstrobe); end
        vectors++; if (qbit !== 1'b0) begin miscompares++; $display("FAIL reset_qbit: got %b want 0", qbit); end
        vectors++; if (qbiten !== 1'b0) begin miscompares++; $display("FAIL reset_qbiten: got %b want 0", qbiten); end
    endtask

    task automatic test_zero();
        int ones;
        do_reset();
        send_block('0);
        idle(L + 4);
        vectors++; if (mq.size() !== 1) begin miscompares++; $display("FAIL zero_strobes: got %0d want 1", mq.size()); end
        if (mq.size() >= 1) begin
            vectors++; if (mq[0] !== '0) begin miscompares++; $display("FAIL zero_q: got %h want 0", mq[0]); end
            vectors++; if (mt[0] !== rel + N) begin miscompares++; $display("FAIL zero_strobe_time: got %0d want %0d", mt[0], rel + N); end
        end
        vectors++; if (rl.size() !== 1) begin miscompares++; $display("FAIL zero_runs: got %0d want 1", rl.size()); end
        if (rl.size() >= 1) begin
            vectors++; if (rl[0] !== L) begin miscompares++; $display("FAIL zero_run_len: got %0d want %0d", rl[0], L); end
            vectors++; if (rs[0] !== rel + N + 1) begin miscompares++; $display("FAIL zero_run_start: got %0d want %0d", rs[0], rel + N + 1); end
        end
        ones = 0;
        foreach (mb[i]) if (mb[i] !== 1'b0) ones++;
        vectors++; if (ones !== 0) begin miscompares++; $display("FAIL zero_qbit: got %0d nonzero bits want 0", ones); end
    endtask

    task automatic test_single_bits();
        logic [N-1:0]   x1, x2;
        logic [N+L-2:0] s;
        s  = SEED;
        x1 = '0; x1[N-1] = 1'b1;
        x2 = '0; x2[0]   = 1'b1;
        do_reset();
        send_block(x1);
        send_block(x2);
        idle(4);
        vectors++; if (mq.size() !== 2) begin miscompares++; $display("FAIL single_strobes: got %0d want 2", mq.size()); end
        if (mq.size() >= 2) begin
            vectors++; if (mq[0] !== s[L-1:0]) begin miscompares++; $display("FAIL first_bit_q: got %h want %h", mq[0], s[L-1:0]); end
            vectors++; if (mq[1] !== s[N+L-2:N-1]) begin miscompares++; $display("FAIL last_bit_q: got %h want %h", mq[1], s[N+L-2:N-1]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] blk[4];
        logic [L-1:0] exp_q[4];
        int bad;
        for (int k = 0; k < 4; k++) begin
            blk[k]   = rand_block();
            exp_q[k] = ref_hash(blk[k]);
        end
        do_reset();
        for (int k = 0; k < 4; k++) send_block(blk[k]);
        idle(L + 4);
        vectors++; if (mq.size() !== 4) begin miscompares++; $display("FAIL b2b_strobes: got %0d want 4", mq.size()); end
        if (mq.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                vectors++; if (mq[k] !== exp_q[k]) begin miscompares++; $display("FAIL b2b_q%0d: got %h want %h", k, mq[k], exp_q[k]); end
            end
            for (int k = 1; k < 4; k++) begin
                vectors++; if (mt[k] - mt[k-1] !== N) begin miscompares++; $display("FAIL b2b_spacing%0d: got %0d want %0d", k, mt[k] - mt[k-1], N); end
            end
        end
        vectors++; if (rl.size() !== 4) begin miscompares++; $display("FAIL b2b_runs: got %0d want 4", rl.size()); end
        if (rl.size() == 4 && mt.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                vectors++; if (rl[k] !== L || rs[k] !== mt[k] + 1) begin
                    miscompares++; $display("FAIL b2b_run%0d: len %0d start %0d want len %0d start %0d", k, rl[k], rs[k], L, mt[k] + 1);
                end
            end
        end
        if (mb.size() == 4*L) begin
            bad = 0;
            for (int k = 0; k < 4; k++)
                for (int b = 0; b < L; b++)
                    if (mb[k*L+b] !== exp_q[k][L-1-b]) bad++;
            vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b_qbit: got %0d wrong bits want 0", bad); end
        end
        vectors++; if (hold_viol !== 0) begin miscompares++; $display("FAIL b2b_q_hold: got %0d changes without strobe want 0", hold_viol); end
    endtask

    task automatic test_linearity();
        logic [N-1:0] a, b;
        a = rand_block();
        b = rand_block();
        do_reset();
        send_block(a);
        send_block(b);
        send_block(a ^ b);
        idle(4);
        vectors++; if (mq.size() !== 3) begin miscompares++; $display("FAIL lin_strobes: got %0d want 3", mq.size()); end
        if (mq.size() == 3) begin
            vectors++; if (mq[2] !== (mq[0] ^ mq[1])) begin miscompares++; $display("FAIL lin_xor: got %h want %h", mq[2], mq[0] ^ mq[1]); end
            vectors++; if (mq[2] !== ref_hash(a ^ b)) begin miscompares++; $display("FAIL lin_model: got %h want %h", mq[2], ref_hash(a ^ b)); end
        end
    endtask

    task automatic test_serializer();
        logic         bits[$];
        logic         ens[$];
        int           bad_bit, en_cnt, late_en;
        s_q = '0;
        s_q[L-1] = 1'b1;
        s_q[0]   = 1'b1;
        s_stb = 1'b1;
        @(posedge clk); #1;
        s_stb = 1'b0;
        for (int i = 0; i < L + 3; i++) begin
            bits.push_back(s_bit);
            ens.push_back(s_en);
            @(posedge clk); #1;
        end
        bad_bit = 0; en_cnt = 0; late_en = 0;
        for (int i = 0; i < L; i++) begin
            if (ens[i] === 1'b1) en_cnt++;
            if (bits[i] !== ((i == 0 || i == L-1) ? 1'b1 : 1'b0)) bad_bit++;
        end
        for (int i = L; i < L + 3; i++) if (ens[i] !== 1'b0) late_en++;
        vectors++; if (bad_bit !== 0) begin miscompares++; $display("FAIL ser_pattern: got %0d wrong bits want 0", bad_bit); end
        vectors++; if (en_cnt !== L) begin miscompares++; $display("FAIL ser_en_high: got %0d want %0d", en_cnt, L); end
        vectors++; if (late_en !== 0) begin miscompares++; $display("FAIL ser_en_low: got %0d late cycles want 0", late_en); end
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] a, b, c;
        a = rand_block();
        b = rand_block();
        c = rand_block();
        do_reset();
        send_block(a);
        for (int i = N-1; i >= N-100; i--) begin
            data = b[i];
            @(posedge clk); #1;
        end
        vectors++; if (q !== ref_hash(a)) begin miscompares++; $display("FAIL mid_pre_q: got %h want %h", q, ref_hash(a)); end
        vectors++; if (qbiten !== 1'b1) begin miscompares++; $display("FAIL mid_pre_qbiten: got %b want 1", qbiten); end
        reset = 1'b0;
        #1;
        vectors++; if (q !== '0) begin miscompares++; $display("FAIL mid_async_q: got %h want 0", q); end
        vectors++; if (qstrobe !== 1'b0 || qbit !== 1'b0 || qbiten !== 1'b0) begin
            miscompares++; $display("FAIL mid_async_ctl: got strobe %b bit %b en %b want 0 0 0", qstrobe, qbit, qbiten);
        end
        repeat (3) begin @(posedge clk); #1; end
        vectors++; if (mq.size() !== 1) begin miscompares++; $display("FAIL mid_no_strobe: got %0d strobes want 1", mq.size()); end
        reset = 1'b1;
        clear_mon();
        rel = cyc;
        send_block(c);
        idle(4);
        vectors++; if (mq.size() !== 1) begin miscompares++; $display("FAIL mid_post_strobes: got %0d want 1", mq.size()); end
        if (mq.size() >= 1) begin
            vectors++; if (mq[0] !== ref_hash(c)) begin miscompares++; $display("FAIL mid_post_q: got %h want %h", mq[0], ref_hash(c)); end
            vectors++; if (mt[0] !== rel + N) begin miscompares++; $display("FAIL mid_post_time: got %0d want %0d", mt[0], rel + N); end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single_bits();
        test_back_to_back();
        test_linearity();
        test_serializer();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
